serial_adder_sub: RTL and testbench

Parametrised multi-cycle adder/subtractor for the ALU datapath; generalises the fixed-width ripple adders to WIDTH bits.
- Processes CHUNK bits per clock through one shared CHUNK-wide ripple slice, so area scales with CHUNK rather than WIDTH.
- Adds a start/busy/done handshake, subtract mode, carry-in, and signed-overflow and zero flags.
- Sits between the ALU operand registers and the result mux.

---
 rtl/serial_adder_sub_pkg.sv | 21 ++
 rtl/serial_adder_sub_adder_nbit.sv | 29 ++
 rtl/serial_adder_sub.sv | 158 +++++++++++++++
 tb/tb_serial_adder_sub.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_sub_pkg.sv
// Shared ALU definitions for the multi-cycle adder/subtractor: FSM states,
// op encoding and a counter-width helper.
package serial_adder_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  // A single-chunk operation still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/serial_adder_sub_adder_nbit.sv
// Combinational N-bit ripple adder; also exposes the carry into its MSB so
// the caller can form the signed-overflow flag.
module adder_nbit #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic [N:0] chain;

  // Bit-serial ripple of the carry through the slice.
  always_comb begin
    chain    = '0;
    sum_o    = '0;
    chain[0] = cin_i;
    for (int i = 0; i < int'(N); i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ chain[i];
      chain[i + 1] = (a_i[i] & b_i[i]) | (chain[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = chain[N];
    cmsb_o = chain[N-1];
  end

endmodule

// File: rtl/serial_adder_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-wide ripple slice is
// reused for WIDTH/CHUNK cycles, with a start/busy/done handshake.
module serial_adder_sub
  import serial_adder_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = idx_width(NCHUNK);

  generate
    if ((CHUNK < 32'd1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 32'd0)) begin : g_bad_params
      $error("serial_adder_sub: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              cy_q, cy_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CHUNK-1:0]  sl_a, sl_b, sl_sum;
  logic              sl_cout, sl_cmsb;
  logic [WIDTH-1:0]  merged;
  logic              last_chunk;
  alu_op_e           op;

  assign op         = alu_op_e'(sub);
  assign sl_a       = a_q[idx_q * CHUNK +: CHUNK];
  assign sl_b       = b_q[idx_q * CHUNK +: CHUNK];
  assign last_chunk = (idx_q == IW'(NCHUNK - 32'd1));

  adder_nbit #(.N(CHUNK)) u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .cin_i  (cy_q),
    .sum_o  (sl_sum),
    .cout_o (sl_cout),
    .cmsb_o (sl_cmsb)
  );

  // Next-state, operand capture, chunk accumulation and result commit.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cy_d     = cy_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    merged   = shadow_q;
    merged[idx_q * CHUNK +: CHUNK] = sl_sum;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = num_1;
          b_d     = (op == ALU_SUB) ? ~num_2 : num_2;
          cy_d    = (op == ALU_SUB) ? 1'b1 : c;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        shadow_d = merged;
        cy_d     = sl_cout;
        if (last_chunk) begin
          // Busy falls and done rises on the same edge as the commit.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = merged;
          carry_d = sl_cout;
          ovf_d   = sl_cmsb ^ sl_cout;
          zero_d  = (merged == '0);
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      idx_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cy_q     <= cy_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Self-checking bench: five serial_adder_sub instances of different WIDTH/CHUNK,
// a directed vector table, multi-cycle corner sequences and a random run.
module tb_serial_adder_sub;

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    int          lane;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  start_v = 5'b0;
  logic        sub_v = 1'b0;
  logic        c_v = 1'b0;
  logic [31:0] n1_v = 32'h0;
  logic [31:0] n2_v = 32'h0;

  wire  [4:0]  busy_w, done_w, carry_w, ovf_w, zero_w;
  wire  [7:0]  s0;
  wire  [31:0] s1;
  wire  [15:0] s2, s3, s4;
  logic [31:0] sum_w [5];

  int wid [5] = '{8, 32, 16, 16, 16};
  int nch [5] = '{2, 8, 16, 4, 1};

  exp_t exp_q [5][$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    sum_w[0] = {24'h0, s0};
    sum_w[1] = s1;
    sum_w[2] = {16'h0, s2};
    sum_w[3] = {16'h0, s3};
    sum_w[4] = {16'h0, s4};
  end

  serial_adder_sub #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v), .num_1(n1_v[7:0]), .num_2(n2_v[7:0]),
    .c(c_v), .busy(busy_w[0]), .done(done_w[0]), .sum(s0), .carry(carry_w[0]),
    .overflow(ovf_w[0]), .zero(zero_w[0]));

  serial_adder_sub #(.WIDTH(32), .CHUNK(4)) u_w32c4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v), .num_1(n1_v), .num_2(n2_v),
    .c(c_v), .busy(busy_w[1]), .done(done_w[1]), .sum(s1), .carry(carry_w[1]),
    .overflow(ovf_w[1]), .zero(zero_w[1]));

  serial_adder_sub #(.WIDTH(16), .CHUNK(1)) u_w16c1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v), .num_1(n1_v[15:0]), .num_2(n2_v[15:0]),
    .c(c_v), .busy(busy_w[2]), .done(done_w[2]), .sum(s2), .carry(carry_w[2]),
    .overflow(ovf_w[2]), .zero(zero_w[2]));

  serial_adder_sub #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub_v), .num_1(n1_v[15:0]), .num_2(n2_v[15:0]),
    .c(c_v), .busy(busy_w[3]), .done(done_w[3]), .sum(s3), .carry(carry_w[3]),
    .overflow(ovf_w[3]), .zero(zero_w[3]));

  serial_adder_sub #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
    .clk(clk), .rst(rst), .start(start_v[4]), .sub(sub_v), .num_1(n1_v[15:0]), .num_2(n2_v[15:0]),
    .c(c_v), .busy(busy_w[4]), .done(done_w[4]), .sum(s4), .carry(carry_w[4]),
    .overflow(ovf_w[4]), .zero(zero_w[4]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: wide integer add, overflow from operand/result sign bits.
  function automatic exp_t model(input int w, input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input logic cc);
    exp_t        r;
    logic [31:0] mask, aa, bb;
    logic [32:0] full;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    aa     = a & mask;
    bb     = (s ? ~b : b) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + {32'h0, (s ? 1'b1 : cc)};
    r.sum  = full[31:0] & mask;
    r.carry = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    r.zero = (r.sum == 32'h0);
    return r;
  endfunction

  // Scoreboard: every done pops the oldest expectation for that lane.
  always @(negedge clk) begin
    for (int l = 0; l < 5; l++) begin
      if (done_w[l] === 1'b1) begin
        if (exp_q[l].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done lane%0d: got done=1 expected no result", l);
        end else begin
          mon_e = exp_q[l].pop_front();
          chk($sformatf("sum_l%0d", l), {32'h0, sum_w[l]}, {32'h0, mon_e.sum});
          chk($sformatf("carry_l%0d", l), {63'h0, carry_w[l]}, {63'h0, mon_e.carry});
          chk($sformatf("overflow_l%0d", l), {63'h0, ovf_w[l]}, {63'h0, mon_e.ovf});
          chk($sformatf("zero_l%0d", l), {63'h0, zero_w[l]}, {63'h0, mon_e.zero});
        end
      end
    end
  end

  // One operation; poke>0 re-pulses start with junk operands in that RUN cycle.
  task automatic run_op(input int lane, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic cc, input exp_t e, input int poke);
    int   cyc;
    logic busy_ok;
    @(negedge clk);
    sub_v = s; n1_v = a; n2_v = b; c_v = cc;
    start_v[lane] = 1'b1;
    exp_q[lane].push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    busy_ok = 1'b1;
    start_v[lane] = 1'b0;
    n1_v = $urandom; n2_v = $urandom; sub_v = 1'($urandom); c_v = 1'($urandom);
    while (done_w[lane] !== 1'b1 && cyc <= nch[lane] + 3) begin
      busy_ok = busy_ok & (busy_w[lane] === 1'b1);
      @(negedge clk);
      cyc++;
      start_v[lane] = (cyc == poke);
      n1_v = $urandom; n2_v = $urandom;
    end
    start_v[lane] = 1'b0;
    chk($sformatf("latency_l%0d", lane), 64'(cyc), 64'(nch[lane] + 1));
    chk($sformatf("busy_in_run_l%0d", lane), {63'h0, busy_ok}, 64'd1);
    chk($sformatf("busy_at_done_l%0d", lane), {63'h0, busy_w[lane]}, 64'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    int unsigned sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 32'h0;
    if (sel == 1) return 32'hFFFF_FFFF;
    return $urandom;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [12];
    logic [31:0] ra, rb;
    logic        rs, rc;

    vecs[0]  = vec_t'{0, 1'b0, 32'h7F, 32'h01, 1'b0, exp_t'{32'h80, 1'b0, 1'b1, 1'b0}};
    vecs[1]  = vec_t'{0, 1'b1, 32'h05, 32'h05, 1'b0, exp_t'{32'h00, 1'b1, 1'b0, 1'b1}};
    vecs[2]  = vec_t'{0, 1'b1, 32'h03, 32'h05, 1'b0, exp_t'{32'hFE, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = vec_t'{1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, exp_t'{32'h0, 1'b1, 1'b0, 1'b1}};
    vecs[4]  = vec_t'{0, 1'b0, 32'h80, 32'h80, 1'b0, exp_t'{32'h00, 1'b1, 1'b1, 1'b1}};
    vecs[5]  = vec_t'{0, 1'b1, 32'h80, 32'h01, 1'b0, exp_t'{32'h7F, 1'b1, 1'b1, 1'b0}};
    vecs[6]  = vec_t'{0, 1'b0, 32'hFF, 32'hFF, 1'b1, exp_t'{32'hFF, 1'b1, 1'b0, 1'b0}};
    vecs[7]  = vec_t'{0, 1'b1, 32'h10, 32'h01, 1'b1, exp_t'{32'h0F, 1'b1, 1'b0, 1'b0}};
    vecs[8]  = vec_t'{4, 1'b0, 32'h7FFF, 32'h0001, 1'b0, exp_t'{32'h8000, 1'b0, 1'b1, 1'b0}};
    vecs[9]  = vec_t'{2, 1'b1, 32'h0000, 32'h0001, 1'b0, exp_t'{32'hFFFF, 1'b0, 1'b0, 1'b0}};
    vecs[10] = vec_t'{3, 1'b0, 32'h8000, 32'h8000, 1'b1, exp_t'{32'h0001, 1'b1, 1'b1, 1'b0}};
    vecs[11] = vec_t'{1, 1'b1, 32'h8000_0000, 32'h1, 1'b0, exp_t'{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < 5; l++)
      chk($sformatf("reset_state_l%0d", l),
          {27'h0, busy_w[l], done_w[l], carry_w[l], ovf_w[l], zero_w[l], sum_w[l]}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].lane, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e, 0);

    // start pulses and operand churn during RUN must not disturb the result
    run_op(1, 1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, exp_t'{32'h2222_2221, 1'b0, 1'b0, 1'b0}, 3);
    run_op(3, 1'b1, 32'h0, 32'h0, 1'b1, exp_t'{32'h0, 1'b1, 1'b0, 1'b1}, 2);

    // back-to-back on the 8/4 lane with start held through RUN and DONE
    @(negedge clk);
    sub_v = 1'b0; n1_v = 32'h01; n2_v = 32'h02; c_v = 1'b0;
    start_v[0] = 1'b1;
    exp_q[0].push_back(model(8, 1'b0, 32'h01, 32'h02, 1'b0));
    @(posedge clk);
    @(negedge clk);
    sub_v = 1'b1; n1_v = 32'h7F; n2_v = 32'hFF; c_v = 1'b0;
    exp_q[0].push_back(model(8, 1'b1, 32'h7F, 32'hFF, 1'b0));
    repeat (2) @(negedge clk);
    chk("b2b_first_done", {63'h0, done_w[0]}, 64'd1);
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("b2b_no_idle_busy", {62'h0, busy_w[0], done_w[0]}, 64'd2);
    repeat (2) @(negedge clk);
    chk("b2b_second_done", {63'h0, done_w[0]}, 64'd1);

    // reset in RUN cycle 3 abandons the operation and clears the outputs
    @(negedge clk);
    sub_v = 1'b0; n1_v = 32'h1111_1111; n2_v = 32'h2222_2222; c_v = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_run",
        {27'h0, busy_w[1], done_w[1], carry_w[1], ovf_w[1], zero_w[1], sum_w[1]}, 64'd0);
    rst = 1'b0;
    run_op(1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b1,
           model(32, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b1), 0);

    for (int l = 0; l < 5; l++) begin
      for (int k = 0; k < 120; k++) begin
        ra = rnd_op(); rb = rnd_op();
        rs = 1'($urandom); rc = 1'($urandom);
        run_op(l, rs, ra, rb, rc, model(wid[l], rs, ra, rb, rc), 0);
      end
    end

    repeat (20) @(negedge clk);
    for (int l = 0; l < 5; l++)
      chk($sformatf("drained_l%0d", l), 64'(exp_q[l].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
